// File: rtl/video_timing_gen_if.sv
// Control inputs and registered pixel/timing outputs of video_timing_gen.
interface video_timing_gen_if;
   logic        enable;
   logic [23:0] bg_color;
   logic [23:0] pixel_data_out;
   logic        hsync_out;
   logic        vsync_out;
   logic        vde_out;
   logic        frame_start;
   logic        busy;

   modport master (
      output enable, bg_color,
      input  pixel_data_out, hsync_out, vsync_out, vde_out, frame_start, busy
   );

   modport slave (
      input  enable, bg_color,
      output pixel_data_out, hsync_out, vsync_out, vde_out, frame_start, busy
   );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: active/front porch/sync/back porch per line and per frame.
// Define TEST_PATTERN_EN to fill the active area with a counter pattern instead of bg_color.
module video_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic              clk,
   input  logic              arst,
   video_timing_gen_if.slave vif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] L_H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0] L_H_ACT    = 12'(H_ACTIVE);
   localparam logic [11:0] L_HS_BEG   = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] L_HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] L_V_LAST   = 12'(V_TOTAL - 1);
   localparam logic [11:0] L_V_ACT    = 12'(V_ACTIVE);
   localparam logic [11:0] L_VS_BEG   = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] L_VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [11:0] r_h_cnt;
   logic [11:0] r_v_cnt;

   logic        w_h_wrap;
   logic        w_frame_end;
   logic        w_active;
   logic        w_vde;
   logic        w_hs;
   logic        w_vs;
   logic        w_fs;
   logic [23:0] w_pix_src;
   logic [23:0] w_pix;

   logic [23:0] r_pix;
   logic        r_vde;
   logic        r_hs;
   logic        r_vs;
   logic        r_fs;

   assign w_h_wrap    = (r_h_cnt == L_H_LAST);
   assign w_frame_end = w_h_wrap && (r_v_cnt == L_V_LAST);
   assign w_active    = (r_state != S_IDLE);

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Stopping only takes effect at the last pixel of a frame, so frames are never cut short.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:     if (vif.enable) w_state_nxt = S_RUN;
         S_RUN:      if (!vif.enable) w_state_nxt = S_STOPPING;
         S_STOPPING: begin
            if (vif.enable)       w_state_nxt = S_RUN;
            else if (w_frame_end) w_state_nxt = S_IDLE;
         end
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   // Counters sit at zero in IDLE, so the start edge already presents pixel (0,0).
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (r_state == S_IDLE) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (w_h_wrap) begin
         r_h_cnt <= '0;
         r_v_cnt <= (r_v_cnt == L_V_LAST) ? 12'd0 : r_v_cnt + 12'd1;
      end else begin
         r_h_cnt <= r_h_cnt + 12'd1;
      end
   end

   always_comb begin
      w_vde = w_active && (r_h_cnt < L_H_ACT) && (r_v_cnt < L_V_ACT);
      w_hs  = w_active && (r_h_cnt >= L_HS_BEG) && (r_h_cnt < L_HS_END);
      w_vs  = w_active && (r_v_cnt >= L_VS_BEG) && (r_v_cnt < L_VS_END);
      w_fs  = w_active && (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
`ifdef TEST_PATTERN_EN
      w_pix_src = {r_h_cnt[7:0], r_v_cnt[7:0], r_h_cnt[7:0] ^ r_v_cnt[7:0]};
`else
      w_pix_src = vif.bg_color;
`endif
      w_pix = w_vde ? w_pix_src : 24'd0;
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         r_pix <= '0;
         r_vde <= 1'b0;
         r_hs  <= 1'b0;
         r_vs  <= 1'b0;
         r_fs  <= 1'b0;
      end else begin
         r_pix <= w_pix;
         r_vde <= w_vde;
         r_hs  <= w_hs;
         r_vs  <= w_vs;
         r_fs  <= w_fs;
      end
   end

   assign vif.pixel_data_out = r_pix;
   assign vif.vde_out        = r_vde;
   assign vif.hsync_out      = r_hs;
   assign vif.vsync_out      = r_vs;
   assign vif.frame_start    = r_fs;
   assign vif.busy           = w_active;

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width in clocks.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in clocks.
REQ-005 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have port clk, input, 1, the single clock; async logic is prohibited.
REQ-010 SHALL have port arst, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port enable, input, 1, request to generate frames.
REQ-012 SHALL have port bg_color, input, 24, active-area colour when the pattern is compiled out.
REQ-013 SHALL have port pixel_data_out, output, 24, pixel value.
REQ-014 SHALL have ports hsync_out, vsync_out, vde_out, output, 1 each, active-high timing strobes.
REQ-015 SHALL have port frame_start, output, 1, one-cycle pulse with the first pixel of each frame.
REQ-016 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-017 SHALL derive H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; h_cnt and v_cnt SHALL be 12 bits wide.
REQ-018 SHALL order each line as active, front porch, sync, back porch, and each frame the same way in lines.
REQ-019 SHALL run a three-state FSM: IDLE, RUN, STOPPING.
REQ-020 In IDLE, enable sampled high SHALL move to RUN with h_cnt=0 and v_cnt=0 on that same edge.
REQ-021 In RUN, enable sampled low SHALL move to STOPPING; in STOPPING, enable sampled high SHALL return to RUN.
REQ-022 In RUN or STOPPING, h_cnt SHALL increment every clock and wrap to 0 at H_TOTAL-1; v_cnt SHALL increment on h_cnt wrap and wrap to 0 at V_TOTAL-1.
REQ-023 At (H_TOTAL-1, V_TOTAL-1), STOPPING SHALL go to IDLE and RUN SHALL stay in RUN; enable toggling never truncates a frame.
REQ-024 Outputs SHALL be registered with one-cycle latency, so outputs at edge n+1 reflect the counters at edge n.
REQ-025 vde_out SHALL be high iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-026 hsync_out SHALL be high iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, on every line including blanking lines.
REQ-027 vsync_out SHALL be high iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines.
REQ-028 frame_start SHALL be high iff h_cnt=0 and v_cnt=0, and only while not IDLE.
REQ-029 pixel_data_out SHALL be 0 whenever vde_out is low.
REQ-030 In IDLE, all strobes and pixel_data_out SHALL be 0 from the cycle after IDLE is entered.

Reset
REQ-031 arst low SHALL immediately force state IDLE, counters 0 and every output 0, including mid-frame.
REQ-032 After arst release, generation SHALL start only via REQ-020, never resuming the interrupted frame.

Configuration
REQ-033 With `define TEST_PATTERN_EN, active-area pixel_data_out SHALL be {h_cnt[7:0], v_cnt[7:0], h_cnt[7:0]^v_cnt[7:0]}.
REQ-034 Without TEST_PATTERN_EN, active-area pixel_data_out SHALL be bg_color sampled with the same counters, with no pattern logic synthesised.

Verification (bench parameters: H 4/1/2/1 giving H_TOTAL=8; V 3/1/1/1 giving V_TOTAL=6; frame=48 clocks)
REQ-035 SHALL check: enable high at edge k -> frame_start and vde_out high at edge k+1; vde_out high 4 clocks per line for 3 lines; hsync_out high at line offsets 5-6.
REQ-036 SHALL check: enable continuously high -> frame_start pulses every 48 clocks; vsync_out high for exactly 8 clocks, starting 32 clocks after frame_start.
REQ-037 SHALL check: enable dropped at clock 10 of a frame -> the frame completes all 48 clocks, busy falls at the wrap and outputs stay 0 afterwards.
REQ-038 SHALL check: enable dropped, then raised again during STOPPING -> the next frame_start follows with no gap, exactly 48 clocks later.
REQ-039 SHALL check: arst low at clock 20 mid-frame -> all outputs 0 asynchronously; after release with enable high, frame_start appears 2 edges later.
REQ-040 SHALL check, with TEST_PATTERN_EN: pixel (h=2, v=1) is 0x020103; without it, bg_color=0xABCDEF gives 0xABCDEF only while vde_out is high.
